// File: rtl/mod_counter_gen_pkg.sv
// Shared types and constants for the parametrised modulo counter.
package mod_counter_gen_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int unsigned WRAP_CNT_W = 8;

endpackage

// File: rtl/mod_counter_gen_if.sv
// Control/status bundle for mod_counter_gen.
// wrap_cnt is present only when MOD_COUNTER_GEN_WRAP_CNT_EN is defined.
interface mod_counter_gen_if #(
  parameter int unsigned WIDTH = 4
);
  import mod_counter_gen_pkg::*;

  logic             sync_clr;
  logic             en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;
  logic             match;
  logic             match_seen;
`ifdef MOD_COUNTER_GEN_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_cnt;
`endif

  modport master (
    output sync_clr, en, dir, load, load_val, start,
    input  count, tc, busy, done, match, match_seen
`ifdef MOD_COUNTER_GEN_WRAP_CNT_EN
    , input wrap_cnt
`endif
  );

  modport slave (
    input  sync_clr, en, dir, load, load_val, start,
    output count, tc, busy, done, match, match_seen
`ifdef MOD_COUNTER_GEN_WRAP_CNT_EN
    , output wrap_cnt
`endif
  );

endinterface

// File: rtl/mod_counter_gen_step.sv
// Combinational modulo step: next count and wrap flag for one up/down step.
module mod_counter_gen_step
  import mod_counter_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 10
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  output logic [WIDTH-1:0] cnt_next,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

  always_comb begin
    cnt_next = count;
    wrap     = 1'b0;
    if (dir == DIR_DN) begin
      if (count == '0) begin
        cnt_next = MaxVal;
        wrap     = 1'b1;
      end else begin
        cnt_next = count - WIDTH'(1);
      end
    end else begin
      if (count == MaxVal) begin
        cnt_next = '0;
        wrap     = 1'b1;
      end else begin
        cnt_next = count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mod_counter_gen.sv
// Parametrised modulo counter with load, one-shot mode, tc pulse and sticky match.
// Optional wrap_cnt output enabled by MOD_COUNTER_GEN_WRAP_CNT_EN.
module mod_counter_gen
  import mod_counter_gen_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MOD       = 10,
  parameter int unsigned MATCH_VAL = 12,
  parameter int unsigned ONESHOT   = 0
) (
  input logic             clk,
  input logic             rst_n,
  mod_counter_gen_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 32 || MOD < 2 ||
      longint'(MOD) > (longint'(1) << WIDTH)) begin : gen_param_err
    $error("mod_counter_gen: illegal WIDTH/MOD combination");
  end

  localparam logic [WIDTH-1:0] MaxVal     = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   ModVal     = (WIDTH + 1)'(MOD);
  localparam bit               OneShot    = (ONESHOT != 0);
  // An unreachable compare value must leave match tied low, not aliased by truncation.
  localparam bit               MatchReach = (MATCH_VAL < MOD);
  localparam state_e           ResetState = OneShot ? StIdle : StRun;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, step_next;
  logic             tc_q, tc_d, done_q, done_d, seen_q, seen_d;
  logic             step_wrap, match, arm;

  mod_counter_gen_step #(
    .WIDTH(WIDTH),
    .MOD  (MOD)
  ) u_step (
    .count   (count_q),
    .dir     (bus.dir),
    .cnt_next(step_next),
    .wrap    (step_wrap)
  );

  assign match = MatchReach && (count_q == WIDTH'(MATCH_VAL));
  assign arm   = OneShot && bus.start && (state_q != StRun);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    seen_d  = seen_q | match;
    if (bus.sync_clr) begin
      state_d = ResetState;
      count_d = '0;
      done_d  = 1'b0;
      seen_d  = 1'b0;
    end else if (bus.load) begin
      count_d = ({1'b0, bus.load_val} >= ModVal) ? MaxVal : bus.load_val;
    end else if (arm) begin
      state_d = StRun;
      count_d = (bus.dir == DIR_DN) ? MaxVal : '0;
      done_d  = 1'b0;
    end else if (bus.en && state_q == StRun) begin
      count_d = step_next;
      tc_d    = step_wrap;
      if (OneShot && step_wrap) begin
        state_d = StDone;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ResetState;
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      seen_q  <= seen_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.tc         = tc_q;
  assign bus.busy       = (state_q == StRun);
  assign bus.done       = done_q;
  assign bus.match      = match;
  assign bus.match_seen = seen_q;

`ifdef MOD_COUNTER_GEN_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

  // Counts alongside tc_d so wrap_cnt and tc change on the same edge.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (bus.sync_clr || arm) begin
      wrap_cnt_d = '0;
    end else if (tc_d && wrap_cnt_q != '1) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_cnt_q <= '0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign bus.wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_mod_counter_gen.sv
// Scoreboard bench for mod_counter_gen: free-running, match, one-shot (and wrap_cnt) instances.
module tb_mod_counter_gen;

  typedef struct packed {
    logic [1:0] dut;
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;
    logic       match;
    logic       seen;
    logic [7:0] wrap;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  exp_t  exp_q[$];
  string name_q[$];
  event  async_chk;

  mod_counter_gen_if #(.WIDTH(4)) if_free  ();
  mod_counter_gen_if #(.WIDTH(4)) if_match ();
  mod_counter_gen_if #(.WIDTH(4)) if_one   ();

  mod_counter_gen #(.WIDTH(4), .MOD(10), .MATCH_VAL(12), .ONESHOT(0)) u_free (
    .clk(clk), .rst_n(rst_n), .bus(if_free)
  );
  mod_counter_gen #(.WIDTH(4), .MOD(10), .MATCH_VAL(7), .ONESHOT(0)) u_match (
    .clk(clk), .rst_n(rst_n), .bus(if_match)
  );
  mod_counter_gen #(.WIDTH(4), .MOD(5), .MATCH_VAL(12), .ONESHOT(1)) u_one (
    .clk(clk), .rst_n(rst_n), .bus(if_one)
  );
`ifdef MOD_COUNTER_GEN_WRAP_CNT_EN
  mod_counter_gen_if #(.WIDTH(4)) if_wrap ();
  mod_counter_gen #(.WIDTH(4), .MOD(2), .MATCH_VAL(12), .ONESHOT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(if_wrap)
  );
`endif

  function automatic exp_t mk(input logic [1:0] d, input int c, input bit t, input bit b,
                              input bit dn, input bit m, input bit s, input int w);
    exp_t e;
    e.dut = d; e.count = 4'(c); e.tc = t; e.busy = b; e.done = dn;
    e.match = m; e.seen = s; e.wrap = 8'(w);
    return e;
  endfunction

  function automatic exp_t sample(input logic [1:0] d);
    exp_t a;
    a = '0;
    a.dut = d;
    case (d)
      2'd0: begin
        a.count = if_free.count; a.tc = if_free.tc; a.busy = if_free.busy;
        a.done = if_free.done; a.match = if_free.match; a.seen = if_free.match_seen;
      end
      2'd1: begin
        a.count = if_match.count; a.tc = if_match.tc; a.busy = if_match.busy;
        a.done = if_match.done; a.match = if_match.match; a.seen = if_match.match_seen;
      end
      2'd2: begin
        a.count = if_one.count; a.tc = if_one.tc; a.busy = if_one.busy;
        a.done = if_one.done; a.match = if_one.match; a.seen = if_one.match_seen;
      end
      default: begin
`ifdef MOD_COUNTER_GEN_WRAP_CNT_EN
        a.count = if_wrap.count; a.tc = if_wrap.tc; a.busy = if_wrap.busy;
        a.done = if_wrap.done; a.match = if_wrap.match; a.seen = if_wrap.match_seen;
        a.wrap = if_wrap.wrap_cnt;
`endif
      end
    endcase
    return a;
  endfunction

  task automatic push_exp(input string n, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_free.sync_clr = 0; if_free.en = 0; if_free.dir = 0; if_free.load = 0;
    if_free.load_val = 0; if_free.start = 0;
    if_match.sync_clr = 0; if_match.en = 0; if_match.dir = 0; if_match.load = 0;
    if_match.load_val = 0; if_match.start = 0;
    if_one.sync_clr = 0; if_one.en = 0; if_one.dir = 0; if_one.load = 0;
    if_one.load_val = 0; if_one.start = 0;
`ifdef MOD_COUNTER_GEN_WRAP_CNT_EN
    if_wrap.sync_clr = 0; if_wrap.en = 0; if_wrap.dir = 0; if_wrap.load = 0;
    if_wrap.load_val = 0; if_wrap.start = 0;
`endif
  endtask

  // Monitor: every expectation queued before an edge is compared at the following negedge.
  always begin
    exp_t  e, a;
    string n;
    @(negedge clk or async_chk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = sample(e.dut);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s dut=%0d: got count=%0d tc=%b busy=%b done=%b match=%b seen=%b wrap=%0d; want count=%0d tc=%b busy=%b done=%b match=%b seen=%b wrap=%0d",
                 n, e.dut, a.count, a.tc, a.busy, a.done, a.match, a.seen, a.wrap,
                 e.count, e.tc, e.busy, e.done, e.match, e.seen, e.wrap);
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_all();
    rst_n = 1'b0;
    tick();
    tick();
    push_exp("rst_free",  mk(0, 0, 0, 1, 0, 0, 0, 0));
    push_exp("rst_match", mk(1, 0, 0, 1, 0, 0, 0, 0));
    push_exp("rst_one",   mk(2, 0, 0, 0, 0, 0, 0, 0));
    tick();
    rst_n = 1'b1;

    // Free-running up count through two wraps.
    if_free.en = 1;
    for (int k = 1; k <= 25; k++) begin
      push_exp("free_up", mk(0, k % 10, (k % 10) == 0, 1, 0, 0, 0, 0));
      tick();
    end
    if_free.en = 0;

    // Down count from reset with MATCH_VAL=7.
    if_match.dir = 1; if_match.en = 1;
    push_exp("dn_wrap",    mk(1, 9, 1, 1, 0, 0, 0, 0)); tick();
    push_exp("dn_8",       mk(1, 8, 0, 1, 0, 0, 0, 0)); tick();
    push_exp("dn_7_match", mk(1, 7, 0, 1, 0, 1, 0, 0)); tick();
    push_exp("seen_set",   mk(1, 6, 0, 1, 0, 0, 1, 0)); tick();
    if_match.en = 0;
    push_exp("seen_hold",  mk(1, 6, 0, 1, 0, 0, 1, 0)); tick();
    if_match.sync_clr = 1;
    push_exp("clr_seen",   mk(1, 0, 0, 1, 0, 0, 0, 0)); tick();
    if_match.sync_clr = 0; if_match.load = 1; if_match.load_val = 7;
    push_exp("load_match", mk(1, 7, 0, 1, 0, 1, 0, 0)); tick();
    if_match.load = 0; if_match.sync_clr = 1;
    push_exp("clr_wins",   mk(1, 0, 0, 1, 0, 0, 0, 0)); tick();
    if_match.sync_clr = 0; if_match.dir = 0;

    // Load clamp, load priority over step, down wrap.
    if_free.load = 1; if_free.load_val = 13; if_free.en = 1;
    push_exp("load_clamp", mk(0, 9, 0, 1, 0, 0, 0, 0)); tick();
    if_free.load = 0;
    push_exp("load_wrap",  mk(0, 0, 1, 1, 0, 0, 0, 0)); tick();
    if_free.load = 1; if_free.load_val = 3;
    push_exp("load_3",     mk(0, 3, 0, 1, 0, 0, 0, 0)); tick();
    if_free.load = 0; if_free.dir = 1;
    push_exp("dn_2",       mk(0, 2, 0, 1, 0, 0, 0, 0)); tick();
    push_exp("dn_1",       mk(0, 1, 0, 1, 0, 0, 0, 0)); tick();
    push_exp("dn_0",       mk(0, 0, 0, 1, 0, 0, 0, 0)); tick();
    push_exp("dn_wrap9",   mk(0, 9, 1, 1, 0, 0, 0, 0)); tick();
    if_free.sync_clr = 1; if_free.load = 1; if_free.load_val = 5;
    push_exp("clr_over_load", mk(0, 0, 0, 1, 0, 0, 0, 0)); tick();
    if_free.sync_clr = 0; if_free.load = 0; if_free.en = 0; if_free.dir = 0;

    // One-shot, MOD=5.
    if_one.en = 1;
    push_exp("idle_hold", mk(2, 0, 0, 0, 0, 0, 0, 0)); tick();
    if_one.start = 1;
    push_exp("arm",       mk(2, 0, 0, 1, 0, 0, 0, 0)); tick();
    if_one.start = 0;
    for (int k = 1; k <= 4; k++) begin
      push_exp("run_up", mk(2, k, 0, 1, 0, 0, 0, 0));
      tick();
    end
    push_exp("done_wrap",    mk(2, 0, 1, 0, 1, 0, 0, 0)); tick();
    push_exp("done_hold",    mk(2, 0, 0, 0, 1, 0, 0, 0)); tick();
    push_exp("done_hold2",   mk(2, 0, 0, 0, 1, 0, 0, 0)); tick();
    if_one.start = 1;
    push_exp("rearm",        mk(2, 0, 0, 1, 0, 0, 0, 0)); tick();
    push_exp("start_in_run", mk(2, 1, 0, 1, 0, 0, 0, 0)); tick();
    if_one.start = 0; if_one.en = 0;
    push_exp("en0_hold",     mk(2, 1, 0, 1, 0, 0, 0, 0)); tick();
    if_one.en = 1; if_one.dir = 1;
    push_exp("dir_flip",     mk(2, 0, 0, 1, 0, 0, 0, 0)); tick();
    push_exp("dn_wrap_done", mk(2, 4, 1, 0, 1, 0, 0, 0)); tick();
    if_one.start = 1;
    push_exp("arm_dn",       mk(2, 4, 0, 1, 0, 0, 0, 0)); tick();
    if_one.start = 0;
    push_exp("run_dn",       mk(2, 3, 0, 1, 0, 0, 0, 0)); tick();
    if_one.en = 0;

    // Asynchronous reset mid-run at count 6, checked before any clock edge.
    if_free.en = 1;
    for (int k = 1; k <= 6; k++) begin
      push_exp("pre_rst", mk(0, k, 0, 1, 0, 0, 0, 0));
      tick();
    end
    rst_n = 1'b0;
    #1;
    push_exp("async_free",  mk(0, 0, 0, 1, 0, 0, 0, 0));
    push_exp("async_match", mk(1, 0, 0, 1, 0, 0, 0, 0));
    push_exp("async_one",   mk(2, 0, 0, 0, 0, 0, 0, 0));
    ->async_chk;
    #1;
    if_free.en = 0;
    tick();
    rst_n = 1'b1;
    push_exp("post_rst", mk(0, 0, 0, 1, 0, 0, 0, 0)); tick();

    checks++;
    if (if_free.count !== 4'd0) begin
      failures++;
      $display("FAIL direct_free_count: got %0d, want 0", if_free.count);
    end
    checks++;
    if (if_free.busy !== 1'b1 || if_free.tc !== 1'b0) begin
      failures++;
      $display("FAIL direct_free_busy_tc: got busy=%b tc=%b, want busy=1 tc=0",
               if_free.busy, if_free.tc);
    end
    checks++;
    if (if_match.match_seen !== 1'b0) begin
      failures++;
      $display("FAIL direct_match_seen: got %b, want 0", if_match.match_seen);
    end
    checks++;
    if (if_one.busy !== 1'b0 || if_one.done !== 1'b0) begin
      failures++;
      $display("FAIL direct_one_idle: got busy=%b done=%b, want busy=0 done=0",
               if_one.busy, if_one.done);
    end

`ifdef MOD_COUNTER_GEN_WRAP_CNT_EN
    if_wrap.en = 1;
    for (int k = 1; k <= 600; k++) begin
      if (k == 20)  push_exp("wrap_cnt_20",  mk(3, 0, 1, 1, 0, 0, 0, 10));
      if (k == 600) push_exp("wrap_cnt_sat", mk(3, 0, 1, 1, 0, 0, 0, 255));
      tick();
    end
    if_wrap.en = 0; if_wrap.sync_clr = 1;
    push_exp("wrap_cnt_clr", mk(3, 0, 0, 1, 0, 0, 0, 0)); tick();
    if_wrap.sync_clr = 0;
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
